// File: rtl/stream_mux_nto1_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: arbitration mode encodings.
package stream_mux_nto1_pkg;

   localparam int MUX_MODE_SELECT = 0;
   localparam int MUX_MODE_RR     = 1;

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request scanning upward from ptr,
// wrapping at CHANNELS (which need not be a power of two).
module rr_arbiter #(
   parameter int CHANNELS = 4,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SELW-1:0]     ptr,
   output logic [SELW-1:0]     gnt_idx,
   output logic                gnt_any
);

   // Scan from farthest to nearest so the request closest to ptr is the one left standing.
   always_comb begin : scan
      int j;
      gnt_idx = '0;
      gnt_any = 1'b0;
      j       = 0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         j = ((int'(ptr) + k) >= CHANNELS) ? (int'(ptr) + k - CHANNELS) : (int'(ptr) + k);
         if (req[j]) begin
            gnt_idx = j[SELW-1:0];
            gnt_any = 1'b1;
         end else begin
            gnt_idx = gnt_idx;
            gnt_any = gnt_any;
         end
      end
   end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready multiplexer with a single registered output stage; grant comes from
// an explicit select (MODE 0) or a round-robin arbiter (MODE 1).
module stream_mux_nto1
   import stream_mux_nto1_pkg::*;
#(
   parameter int SIZE     = 16,
   parameter int CHANNELS = 4,
   parameter int MODE     = 0,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CHANNELS*SIZE-1:0] in_data,
   input  logic [CHANNELS-1:0]      in_valid,
   output logic [CHANNELS-1:0]      in_ready,
   input  logic [SELW-1:0]          sel,
   output logic [SIZE-1:0]          out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SELW-1:0]          out_chan
);

   logic [SIZE-1:0]     out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic [SELW-1:0]     out_chan_q, out_chan_d;
   logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [SELW-1:0]     gnt_idx_s;
   logic                gnt_any_s;
   logic                free_s;
   logic                xfer_in_s;
   logic [CHANNELS-1:0] in_ready_s;
   logic [SIZE-1:0]     mux_data_s;

   assign free_s = !out_valid_q || out_ready;

   generate
      if (MODE == MUX_MODE_RR) begin : g_rr
         logic unused_sel_s;
         assign unused_sel_s = ^sel;
         rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_arb (
            .req     (in_valid),
            .ptr     (rr_ptr_q),
            .gnt_idx (gnt_idx_s),
            .gnt_any (gnt_any_s)
         );
      end else begin : g_sel
         // An out-of-range select never grants.
         always_comb begin
            gnt_idx_s = sel;
            if (int'(sel) < CHANNELS) begin
               gnt_any_s = in_valid[sel];
            end else begin
               gnt_any_s = 1'b0;
            end
         end
      end
   endgenerate

   assign xfer_in_s = !rst && gnt_any_s && free_s;

   always_comb begin
      in_ready_s = '0;
      if (xfer_in_s) begin
         in_ready_s[gnt_idx_s] = 1'b1;
      end else begin
         in_ready_s = '0;
      end
   end

   always_comb begin
      mux_data_s = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         mux_data_s = mux_data_s | ((gnt_idx_s == c[SELW-1:0]) ? in_data[c*SIZE +: SIZE] : '0);
      end
   end

   // A new word may replace one leaving on the same edge, so load takes priority over drain.
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer_in_s) begin
         out_data_d  = mux_data_s;
         out_chan_d  = gnt_idx_s;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      if ((MODE == MUX_MODE_RR) && xfer_in_s) begin
         if (gnt_idx_s == SELW'(CHANNELS - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx_s + SELW'(1);
         end
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: select (4 and 3 channels) and round-robin (4 channels) instances
// share one stimulus stream; a reference model feeds a scoreboard drained by a separate monitor.
module tb_stream_mux_nto1;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic [3:0]  in_valid;
   logic [1:0]  sel;
   logic        out_ready;

   logic [3:0]  rdy0, rdy1;
   logic [2:0]  rdy2;
   logic [15:0] od0, od1, od2;
   logic        ov0, ov1, ov2;
   logic [1:0]  oc0, oc1, oc2;

   int total  = 0;
   int passed = 0;
   bit started = 1'b0;

   typedef struct {
      int          inst;
      logic [15:0] data;
      int          chan;
   } exp_t;
   exp_t sbq[$];

   bit m_ov[3];
   int m_rr[3];

   always #5 clk = ~clk;

   stream_mux_nto1 #(.SIZE(16), .CHANNELS(4), .MODE(0)) u_sel4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
      .sel(sel), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_chan(oc0));

   stream_mux_nto1 #(.SIZE(16), .CHANNELS(4), .MODE(1)) u_rr4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
      .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_chan(oc1));

   stream_mux_nto1 #(.SIZE(16), .CHANNELS(3), .MODE(0)) u_sel3 (
      .clk(clk), .rst(rst), .in_data(in_data[47:0]), .in_valid(in_valid[2:0]), .in_ready(rdy2),
      .sel(sel), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .out_chan(oc2));

   function automatic logic [15:0] get_od(int k);
      case (k)
         0:       return od0;
         1:       return od1;
         default: return od2;
      endcase
   endfunction

   function automatic logic get_ov(int k);
      case (k)
         0:       return ov0;
         1:       return ov1;
         default: return ov2;
      endcase
   endfunction

   function automatic logic [1:0] get_oc(int k);
      case (k)
         0:       return oc0;
         1:       return oc1;
         default: return oc2;
      endcase
   endfunction

   function automatic logic [3:0] get_rdy(int k);
      case (k)
         0:       return rdy0;
         1:       return rdy1;
         default: return {1'b0, rdy2};
      endcase
   endfunction

   // Reference grant: instance 1 is round-robin, the others honour sel.
   function automatic int ref_grant(int k, logic [3:0] v, logic [1:0] s, int rr);
      int ch;
      int idx;
      ch = (k == 2) ? 3 : 4;
      if (k == 1) begin
         for (int i = 0; i < ch; i++) begin
            idx = (rr + i) % ch;
            if (v[idx]) return idx;
         end
         return -1;
      end
      if (int'(s) >= ch) return -1;
      if (v[s]) return int'(s);
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: predicts in_ready, tracks occupancy and queues every accepted word.
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 3; k++) begin
            int         ch;
            int         g;
            bit         free;
            logic [3:0] exp_rdy;
            ch = (k == 2) ? 3 : 4;
            check($sformatf("out_valid[%0d]", k), 32'(get_ov(k)), 32'(m_ov[k]));
            free = !m_ov[k] || out_ready;
            g = ref_grant(k, in_valid, sel, m_rr[k]);
            exp_rdy = 4'b0000;
            if (!rst && g >= 0 && free) exp_rdy[g] = 1'b1;
            check($sformatf("in_ready[%0d]", k), 32'(get_rdy(k)), 32'(exp_rdy));
            if (rst) begin
               m_ov[k] = 1'b0;
               m_rr[k] = 0;
               for (int i = sbq.size() - 1; i >= 0; i--)
                  if (sbq[i].inst == k) sbq.delete(i);
            end else if (exp_rdy != 4'b0000) begin
               sbq.push_back('{k, in_data[g*16 +: 16], g});
               m_ov[k] = 1'b1;
               if (k == 1) m_rr[k] = (g + 1) % ch;
            end else if (m_ov[k] && out_ready) begin
               m_ov[k] = 1'b0;
            end
         end
      end
   end

   // Monitor: every word the consumer accepts must be the oldest expected word of that instance.
   always @(negedge clk) begin
      if (started && !rst && out_ready) begin
         for (int k = 0; k < 3; k++) begin
            if (get_ov(k) === 1'b1) begin
               int hit;
               hit = -1;
               for (int i = 0; i < sbq.size(); i++)
                  if (hit < 0 && sbq[i].inst == k) hit = i;
               if (hit < 0) begin
                  total++;
                  $display("FAIL sb_empty[%0d]: got word %0h expected none", k, get_od(k));
               end else begin
                  check($sformatf("sb_data[%0d]", k), 32'(get_od(k)), 32'(sbq[hit].data));
                  check($sformatf("sb_chan[%0d]", k), 32'(get_oc(k)), 32'(sbq[hit].chan));
                  sbq.delete(hit);
               end
            end
         end
      end
   end

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic drive(input logic r, input logic [3:0] v, input logic [1:0] s, input logic o,
                        input logic [63:0] d);
      rst       = r;
      in_valid  = v;
      sel       = s;
      out_ready = o;
      in_data   = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] d;
      int          exp_seq[5];
      int          sparse_seq[3];
      exp_seq    = '{0, 1, 2, 3, 0};
      sparse_seq = '{3, 0, 3};

      drive(1'b1, 4'hF, 2'd0, 1'b1, rnd64());
      started = 1'b1;
      drive(1'b1, 4'hF, 2'd0, 1'b1, rnd64());
      check("rst_od0", 32'(od0), 32'h0);
      check("rst_od1", 32'(od1), 32'h0);
      check("rst_od2", 32'(od2), 32'h0);
      check("rst_oc1", 32'(oc1), 32'h0);

      d = rnd64();
      d[47:32] = 16'hBEEF;
      drive(1'b0, 4'b0100, 2'd2, 1'b1, d);
      check("sel_data", 32'(od0), 32'hBEEF);
      check("sel_chan", 32'(oc0), 32'd2);
      check("rr_single_chan", 32'(oc1), 32'd2);

      d = rnd64();
      d[15:0] = 16'h1234;
      drive(1'b0, 4'b0001, 2'd0, 1'b1, d);
      check("bp_load", 32'(od0), 32'h1234);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'hF, 2'd0, 1'b0, rnd64());
         check("bp_hold", 32'(od0), 32'h1234);
         check("bp_ready", 32'(rdy0), 32'h0);
      end
      d = rnd64();
      d[31:16] = 16'h5678;
      drive(1'b0, 4'b0010, 2'd1, 1'b1, d);
      check("bp_reload_data", 32'(od0), 32'h5678);
      check("bp_reload_chan", 32'(oc0), 32'd1);

      drive(1'b0, 4'h0, 2'd0, 1'b1, rnd64());
      drive(1'b0, 4'h0, 2'd0, 1'b1, rnd64());
      check("drain_ov0", 32'(ov0), 32'h0);

      drive(1'b1, 4'h0, 2'd0, 1'b1, rnd64());
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'hF, 2'd0, 1'b1, rnd64());
         check($sformatf("rr_fair_%0d", i), 32'(oc1), 32'(exp_seq[i]));
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'b1001, 2'd0, 1'b1, rnd64());
         check($sformatf("rr_sparse_%0d", i), 32'(oc1), 32'(sparse_seq[i]));
      end

      drive(1'b0, 4'h0, 2'd3, 1'b1, rnd64());
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 4'hF, 2'd3, 1'b1, rnd64());
         check("badsel_ready", 32'(rdy2), 32'h0);
         check("badsel_valid", 32'(ov2), 32'h0);
      end

      drive(1'b0, 4'hF, 2'd0, 1'b0, rnd64());
      check("stall_ov1", 32'(ov1), 32'h1);
      drive(1'b1, 4'hF, 2'd0, 1'b0, rnd64());
      check("midrst_ov0", 32'(ov0), 32'h0);
      check("midrst_ov1", 32'(ov1), 32'h0);
      drive(1'b0, 4'hF, 2'd2, 1'b1, rnd64());
      check("midrst_rrptr", 32'(oc1), 32'h0);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 49) == 0), 4'($urandom()), 2'($urandom()),
               ($urandom_range(0, 3) != 0), rnd64());
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 2'd0, 1'b1, rnd64());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
